imem_loader: RTL and testbench
==============================

# imem_loader

Sequential program loader that sits between the testbench/host side and the pipeline's instruction memory. It accepts decoded instruction fields over a valid/ready stream, packs each one into its RV32 word, and writes the words to consecutive instruction-memory addresses. While loading, it holds the core in reset. It is the encode side of the opcode set the control decoder recognises: R-type, I-ALU, LW, SW, BEQ-class branch and HALT.

## Interface
- IMEM_DEPTH, 256: instruction memory depth in 32-bit words (power of two, ≥2).
- ADDR_W, $clog2(IMEM_DEPTH): word-address width.

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin or restart a load session.
- in_valid  in  1  field beat valid.
- in_ready  out  1  loader accepts the beat this cycle.
- in_class  in  3  0 R, 1 I-ALU, 2 LW, 3 SW, 4 BR, 5 HALT, 6–7 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3; in_funct7  in  7.
- in_imm  in  13  immediate; I/LW/SW use [11:0], BR uses [12:1].
- imem_we  out  1; imem_addr  out  ADDR_W; imem_wdata  out  32.
- busy  out  1  session active; core_hold  out  1  core kept in reset.
- done  out  1  session finished.
- overflow_err, illegal_err  out  1 each  sticky error flags.

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE → LOAD on start.
  - LOAD → DONE on HALT accept or on overflow.
  - DONE → LOAD on start.
- Entering LOAD clears the address counter, overflow_err and illegal_err.
- Outputs by state:
  - in_ready = (state==LOAD) && !start.
  - busy = core_hold = (state==LOAD).
  - done = (state==DONE).
- A beat is accepted when in_valid && in_ready.
- Encodings (register fields are always placed as listed):
  - R: {funct7,rs2,rs1,funct3,rd,0110011}.
  - I-ALU: {imm[11:0],rs1,funct3,rd,0010011}.
  - LW: {imm[11:0],rs1,010,rd,0000011}; funct3 is forced to 010.
  - SW: {imm[11:5],rs2,rs1,010,imm[4:0],0100011}; funct3 is forced to 010.
  - BR: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],1100011}; imm[0] is ignored.
  - HALT: 32'h0000007F.
- Address counter is ADDR_W+1 bits wide. It increments by one per written word.
- Illegal class: the beat is consumed and nothing is written. illegal_err is set. The counter is unchanged and the session continues.
- Overflow: if the counter equals IMEM_DEPTH while in LOAD with no HALT written, in_ready is 0. On the same cycle overflow_err is set and the next state is DONE. A HALT in the last slot (address IMEM_DEPTH-1) is legal and does not raise overflow.
- start during LOAD restarts the session: counter goes to 0 and errors clear. A write registered from the previous cycle still issues. In the start cycle itself, in_ready is 0, so no beat is lost.
- start in IDLE or DONE with in_valid high: nothing is accepted until the next cycle.

## Timing
- Registered outputs. A beat accepted at edge N produces imem_we=1 with its address and word during cycle N+1. Latency is 1 cycle.
- Throughput: one word per cycle when in_valid is held high.
- HALT accepted at edge N:
  - HALT is written in cycle N+1.
  - State is DONE from edge N: done=1 and core_hold=0 from cycle N+1.
  - The HALT write and core release occur in the same cycle.
- Reset values: state IDLE, counter 0, imem_we 0, imem_addr 0, imem_wdata 0, in_ready 0, busy 0, core_hold 0, done 0, both error flags 0.
- Reset asserted mid-session aborts immediately and asynchronously. Any pending write is dropped, i.e. imem_we goes to 0 at once.

## Structure
- Package riscv_pkg holds:
  - opcode localparams (R_TYPE, I_TYPE, LW, SW, BR, HLT), also imported by the control decoder;
  - a 3-bit enum instr_class_t;
  - the loader state enum.
- Sub-module instr_encoder: purely combinational class+fields → 32-bit word packer. The top module holds the FSM, counter and output registers.

## Test plan
- R add x3,x1,x2 (f7=0,f3=0) at address 0 → imem_wdata=0x002081B3, imem_addr=0, one cycle after accept.
- Back-to-back beats with no gaps:
  - addi x5,x0,-1 (imm=0xFFF) → 0xFFF00293;
  - LW x6,8(x2) → 0x00812303;
  - SW x7,12(x2) → 0x00712623;
  - written at addresses 0,1,2 on consecutive cycles.
- BR rs1=1, rs2=2, f3=0, imm=-8 (13'h1FF8) → 0xFE208CE3. Then HALT → 0x0000007F, done=1 and core_hold=0 in the same cycle as the HALT write.
- Illegal class 6 between two valid beats → no write, illegal_err=1, the following word lands at the next sequential address.
- IMEM_DEPTH=4: four R beats then a fifth beat → in_ready=0, overflow_err=1, DONE. Then start → counter 0, errors cleared.
- Async reset asserted mid-stream, with a write pending → imem_we drops immediately and all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 opcode constants, instruction-class encoding and loader state type.
// The control decoder imports the same opcodes, so encode and decode stay in step.
package riscv_pkg;

  localparam logic [6:0]  R_TYPE    = 7'b0110011;
  localparam logic [6:0]  I_TYPE    = 7'b0010011;
  localparam logic [6:0]  LW        = 7'b0000011;
  localparam logic [6:0]  SW        = 7'b0100011;
  localparam logic [6:0]  BR        = 7'b1100011;
  localparam logic [6:0]  HLT       = 7'b1111111;
  localparam logic [2:0]  F3_WORD   = 3'b010;
  localparam logic [31:0] HALT_WORD = {25'd0, HLT};

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BR   = 3'd4,
    CLS_HALT = 3'd5,
    CLS_BAD6 = 3'd6,
    CLS_BAD7 = 3'd7
  } instr_class_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer: instruction class plus decoded fields to one RV32 word.
// Classes 6 and 7 produce a zero word with o_legal low.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic [2:0]  i_class,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [12:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  always_comb begin
    o_word  = 32'h0;
    o_legal = 1'b1;
    case (instr_class_t'(i_class))
      CLS_R:    o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, R_TYPE};
      CLS_I:    o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, I_TYPE};
      CLS_LW:   o_word = {i_imm[11:0], i_rs1, F3_WORD, i_rd, LW};
      CLS_SW:   o_word = {i_imm[11:5], i_rs2, i_rs1, F3_WORD, i_imm[4:0], SW};
      // branch offsets are halfword-aligned, so imm[0] never reaches the word
      CLS_BR:   o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], BR};
      CLS_HALT: o_word = HALT_WORD;
      default:  o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Sequential program loader: packs field beats into RV32 words and writes them to
// consecutive instruction-memory addresses while holding the core in reset.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              core_hold,
  output logic              done,
  output logic              overflow_err,
  output logic              illegal_err
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  ld_state_t         r_state, w_next;
  logic [ADDR_W:0]   r_cnt;
  logic              r_we, r_ovf, r_ill;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       w_word;
  logic              w_legal, w_full, w_accept, w_is_halt, w_load;

  instr_encoder u_enc (
    .i_class  (in_class),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_funct3 (in_funct3),
    .i_funct7 (in_funct7),
    .i_imm    (in_imm),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  assign w_load    = (r_state == ST_LOAD);
  assign w_full    = (r_cnt == CNT_FULL);
  assign w_accept  = in_valid && in_ready;
  assign w_is_halt = (instr_class_t'(in_class) == CLS_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD;
      ST_LOAD: begin
        if (start)                       w_next = ST_LOAD;
        else if (w_full)                 w_next = ST_DONE;
        else if (w_accept && w_is_halt)  w_next = ST_DONE;
      end
      ST_DONE: if (start) w_next = ST_LOAD;
      default: w_next = ST_IDLE;
    endcase
  end

  // full counter blocks the beat so nothing is written past the last slot
  always_comb begin
    in_ready  = w_load && !start && !w_full;
    busy      = w_load;
    core_hold = w_load;
    done      = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_ovf   <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_we <= w_accept && w_legal;
      if (w_accept && w_legal) begin
        r_addr  <= r_cnt[ADDR_W-1:0];
        r_wdata <= w_word;
        r_cnt   <= r_cnt + CNT_ONE;
      end
      if (w_accept && !w_legal)          r_ill <= 1'b1;
      if (w_load && !start && w_full)    r_ovf <= 1'b1;
      // start from any state opens a fresh session
      if (start) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
        r_ill <= 1'b0;
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign overflow_err = r_ovf;
  assign illegal_err  = r_ill;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: encoding table, hand sequences for restart,
// illegal, overflow and async reset, plus a randomized run against a session model.
module tb_imem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_class = 3'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [12:0] in_imm = 13'd0;

  logic        in_ready, imem_we, busy, core_hold, done, overflow_err, illegal_err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  logic        q_in_ready, q_imem_we, q_busy, q_core_hold, q_done, q_overflow_err, q_illegal_err;
  logic [1:0]  q_imem_addr;
  logic [31:0] q_imem_wdata;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  imem_loader #(.IMEM_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .core_hold(core_hold), .done(done),
    .overflow_err(overflow_err), .illegal_err(illegal_err)
  );

  imem_loader #(.IMEM_DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(q_in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(q_imem_we), .imem_addr(q_imem_addr), .imem_wdata(q_imem_wdata),
    .busy(q_busy), .core_hold(q_core_hold), .done(q_done),
    .overflow_err(q_overflow_err), .illegal_err(q_illegal_err)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [12:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];
  vec_t v_add, v_sub;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_class  = v.cls;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hold"}, core_hold, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow_err, 0);
    chk({tag, "_ill"}, illegal_err, 0);
  endtask

  // Reference packer built from field weights (bit position = power of two).
  function automatic logic [31:0] ref_enc(input int cls, input int rd, input int rs1,
                                          input int rs2, input int f3, input int f7,
                                          input int imm);
    longint w;
    longint i12;
    i12 = imm % 4096;
    case (cls)
      0: w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 51;
      1: w = i12 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 19;
      2: w = i12 * 2**20 + rs1 * 2**15 + 2 * 2**12 + rd * 2**7 + 3;
      3: w = (i12 / 32) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + 2 * 2**12
             + (i12 % 32) * 2**7 + 35;
      4: w = ((imm / 4096) % 2) * 2**31 + ((imm / 32) % 64) * 2**25 + rs2 * 2**20
             + rs1 * 2**15 + f3 * 2**12 + ((imm / 2) % 16) * 2**8
             + ((imm / 2048) % 2) * 2**7 + 99;
      5: w = 127;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  initial begin
    bit m_load, m_ill, m_ovf, e_we, s;
    int m_addr, e_addr, r;
    logic [31:0] e_data;

    v_add  = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 13'h0000, 32'h002081B3};
    v_sub  = '{3'd0, 5'd10, 5'd11, 5'd12, 3'd0, 7'h20, 13'h0000, 32'h40C58533};
    tbl[0] = '{3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 13'h0FFF, 32'hFFF00293};
    tbl[1] = '{3'd2, 5'd6, 5'd2, 5'd0, 3'd2, 7'h00, 13'h0008, 32'h00812303};
    tbl[2] = '{3'd3, 5'd0, 5'd2, 5'd7, 3'd2, 7'h00, 13'h000C, 32'h00712623};
    tbl[3] = '{3'd2, 5'd1, 5'd3, 5'd9, 3'd7, 7'h55, 13'h0004, 32'h0041A083};
    tbl[4] = v_sub;
    tbl[5] = '{3'd4, 5'd0, 5'd3, 5'd4, 3'd1, 7'h00, 13'h0011, 32'h00419863};
    tbl[6] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 13'h1FF8, 32'hFE208CE3};
    tbl[7] = '{3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 13'h17FF, 32'h7FF10093};
    tbl[8] = '{3'd5, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 13'h0000, 32'h0000007F};

    // reset values
    tick(); tick();
    chk_rst("rst");
    reset = 1'b0;
    tick();
    chk("idle_ready", in_ready, 0);

    // start in IDLE with a beat present: nothing accepted that cycle
    start = 1'b1;
    drive(v_add);
    #1 chk("start_idle_ready", in_ready, 0);
    tick();
    chk("start_idle_we", imem_we, 0);
    chk("load_busy", busy, 1);
    chk("load_hold", core_hold, 1);
    chk("load_done", done, 0);
    start = 1'b0;
    #1 chk("add_ready", in_ready, 1);
    tick();
    chk("add_we", imem_we, 1);
    chk("add_addr", imem_addr, 0);
    chk("add_wdata", imem_wdata, 32'h002081B3);

    // restart in the cycle right after an accept: the pending write still issued above
    start = 1'b1;
    in_valid = 1'b0;
    #1 chk("restart_ready", in_ready, 0);
    tick();
    chk("restart_we", imem_we, 0);
    start = 1'b0;

    // back-to-back encoding table, counter restarts at 0
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      #1 chk($sformatf("tbl%0d_ready", i), in_ready, 1);
      tick();
      chk($sformatf("tbl%0d_we", i), imem_we, 1);
      chk($sformatf("tbl%0d_addr", i), imem_addr, i);
      chk($sformatf("tbl%0d_wdata", i), imem_wdata, tbl[i].exp);
      if (tbl[i].cls == 3'd5) begin
        chk("halt_done", done, 1);
        chk("halt_hold", core_hold, 0);
      end else begin
        chk($sformatf("tbl%0d_hold", i), core_hold, 1);
      end
    end
    in_valid = 1'b0;
    #1 chk("done_ready", in_ready, 0);
    tick();
    chk("after_halt_we", imem_we, 0);

    // illegal class between two valid beats
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(v_add);
    tick();
    chk("ill_pre_addr", imem_addr, 0);
    drive(v_add);
    in_class = 3'd6;
    tick();
    chk("ill_we", imem_we, 0);
    chk("ill_flag", illegal_err, 1);
    chk("ill_busy", busy, 1);
    drive(v_sub);
    tick();
    chk("ill_post_we", imem_we, 1);
    chk("ill_post_addr", imem_addr, 1);
    chk("ill_post_wdata", imem_wdata, 32'h40C58533);
    chk("ill_sticky", illegal_err, 1);

    // async reset with a write pending
    drive(v_add);
    tick();
    chk("prerst_we", imem_we, 1);
    #2 reset = 1'b1;
    #1 chk_rst("async");
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // randomized run against the session model
    m_load = 0; m_ill = 0; m_ovf = 0; m_addr = 0;
    for (int k = 0; k < 400; k++) begin
      s = (k == 0) || ($urandom_range(0, 39) == 0);
      start = s;
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      if (r < 3)       in_class = 3'(6 + (r % 2));
      else if (r == 3) in_class = 3'd5;
      else             in_class = 3'($urandom_range(0, 4));
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_funct3 = 3'($urandom); in_funct7 = 7'($urandom); in_imm = 13'($urandom);
      #1 chk("rnd_ready", in_ready, (m_load && !s && m_addr != DEPTH) ? 1 : 0);
      e_we = 0; e_addr = 0; e_data = 0;
      if (s) begin
        m_load = 1; m_addr = 0; m_ill = 0; m_ovf = 0;
      end else if (m_load) begin
        if (m_addr == DEPTH) begin
          m_ovf = 1; m_load = 0;
        end else if (in_valid) begin
          if (in_class >= 3'd6) m_ill = 1;
          else begin
            e_we = 1; e_addr = m_addr;
            e_data = ref_enc(int'(in_class), int'(in_rd), int'(in_rs1), int'(in_rs2),
                             int'(in_funct3), int'(in_funct7), int'(in_imm));
            m_addr++;
            if (in_class == 3'd5) m_load = 0;
          end
        end
      end
      tick();
      chk("rnd_we", imem_we, e_we);
      if (e_we) begin
        chk("rnd_addr", imem_addr, e_addr);
        chk("rnd_wdata", imem_wdata, e_data);
      end
      chk("rnd_ill", illegal_err, m_ill);
      chk("rnd_ovf", overflow_err, m_ovf);
      chk("rnd_busy", busy, m_load);
      chk("rnd_hold", core_hold, m_load);
      chk("rnd_done", done, !m_load);
    end
    start = 1'b0;
    in_valid = 1'b0;
    tick();

    // overflow on the depth-4 instance
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(v_add);
      tick();
      chk($sformatf("ovf_w%0d_we", i), q_imem_we, 1);
      chk($sformatf("ovf_w%0d_addr", i), q_imem_addr, i);
    end
    drive(v_sub);
    #1 chk("ovf_ready", q_in_ready, 0);
    tick();
    chk("ovf_flag", q_overflow_err, 1);
    chk("ovf_done", q_done, 1);
    chk("ovf_hold", q_core_hold, 0);
    chk("ovf_we", q_imem_we, 0);
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovf_clr", q_overflow_err, 0);
    chk("ovf_busy", q_busy, 1);
    drive(v_sub);
    #1 chk("ovf_restart_ready", q_in_ready, 1);
    tick();
    chk("ovf_restart_we", q_imem_we, 1);
    chk("ovf_restart_addr", q_imem_addr, 0);
    chk("ovf_restart_wdata", q_imem_wdata, 32'h40C58533);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
